// File: rtl/lake_sched_pkg.sv
// rtl/lake_sched_pkg.sv - shared types and constants for the lake schedule controller
// Contents: FSM state enum, default parameter values, config_memory field layout.
package lake_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  localparam int DEF_NUM_DIMS   = 6;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_TIME_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DIM_SEL_WIDTH  = 3;

  // Field layout inside config_memory, packed LSB first.
  localparam int CFG_ENABLE_OFS      = 0;
  localparam int CFG_ENABLE_W        = 1;
  localparam int CFG_DIMS_OFS        = CFG_ENABLE_OFS + CFG_ENABLE_W;
  localparam int CFG_DIMS_W          = DIM_SEL_WIDTH;
  localparam int CFG_EXTENT_OFS      = CFG_DIMS_OFS + CFG_DIMS_W;
  localparam int CFG_EXTENT_W        = DEF_NUM_DIMS * DEF_CNT_WIDTH;
  localparam int CFG_SCHED_START_OFS = CFG_EXTENT_OFS + CFG_EXTENT_W;
  localparam int CFG_SCHED_START_W   = DEF_TIME_WIDTH;
  localparam int CFG_SCHED_DELTA_OFS = CFG_SCHED_START_OFS + CFG_SCHED_START_W;
  localparam int CFG_SCHED_DELTA_W   = DEF_NUM_DIMS * DEF_TIME_WIDTH;
  localparam int CFG_ADDR_START_OFS  = CFG_SCHED_DELTA_OFS + CFG_SCHED_DELTA_W;
  localparam int CFG_ADDR_START_W    = DEF_ADDR_WIDTH;
  localparam int CFG_ADDR_DELTA_OFS  = CFG_ADDR_START_OFS + CFG_ADDR_START_W;
  localparam int CFG_ADDR_DELTA_W    = DEF_NUM_DIMS * DEF_ADDR_WIDTH;
  localparam int CFG_TOTAL_W         = CFG_ADDR_DELTA_OFS + CFG_ADDR_DELTA_W;

endpackage

// File: rtl/lake_sched_ctrl_if.sv
// rtl/lake_sched_ctrl_if.sv - port-side handshake bundle of the schedule controller
// Signals: port_ready (port -> ctrl), step/addr/mux_sel/done/overrun (ctrl -> port).
// Modports: master = controller side, slave = lakespec port side.
interface lake_sched_ctrl_if
  import lake_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                     port_ready;
  logic                     step;
  logic [ADDR_WIDTH-1:0]    addr;
  logic [DIM_SEL_WIDTH-1:0] mux_sel;
  logic                     done;
  logic                     overrun;

  modport master (input port_ready, output step, addr, mux_sel, done, overrun);
  modport slave  (output port_ready, input step, addr, mux_sel, done, overrun);
endinterface

// File: rtl/lake_iter_dom.sv
// rtl/lake_iter_dom.sv - iteration-domain counters with lowest-non-wrapping-dimension encoder
// Ports: clk, rst, clear (return iterators to 0), advance (a step is taken),
//        dimensionality, extent in; mux_sel (dimension to bump), last (all at extent) out.
module lake_iter_dom
  import lake_sched_pkg::*;
#(
  parameter int NUM_DIMS  = DEF_NUM_DIMS,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               advance,
  input  logic [DIM_SEL_WIDTH-1:0]           dimensionality,
  input  logic [NUM_DIMS-1:0][CNT_WIDTH-1:0] extent,
  output logic [DIM_SEL_WIDTH-1:0]           mux_sel,
  output logic                               last
);

  logic [NUM_DIMS-1:0][CNT_WIDTH-1:0] iter;

  // Scan from the top down so the lowest qualifying dimension is written last.
  // Inactive dimensions behave as extent 0: they are always "at extent".
  always_comb begin
    mux_sel = '0;
    last    = 1'b1;
    for (int d = NUM_DIMS - 1; d >= 0; d--) begin
      if (d < int'(dimensionality) && iter[d] != extent[d]) begin
        mux_sel = DIM_SEL_WIDTH'(d);
        last    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      iter <= '0;
    end else if (advance && !last) begin
      for (int d = 0; d < NUM_DIMS; d++) begin
        if (d < int'(mux_sel)) begin
          iter[d] <= '0;
        end else if (d == int'(mux_sel)) begin
          iter[d] <= iter[d] + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/lake_sched_ctrl.sv
// rtl/lake_sched_ctrl.sv - static affine schedule controller for one lakespec port
// Ports: clk, rst (sync, active-high), flush, enable, dimensionality, extent,
//        sched_start, sched_delta, addr_start, addr_delta in; port (lake_sched_ctrl_if.master)
//        carries port_ready in and step/addr/mux_sel/done/overrun out.
// Build option: LAKE_SCHED_CTRL_BACKPRESSURE_EN makes steps wait for port_ready.
module lake_sched_ctrl
  import lake_sched_pkg::*;
#(
  parameter int NUM_DIMS   = DEF_NUM_DIMS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int TIME_WIDTH = DEF_TIME_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                enable,
  input  logic [DIM_SEL_WIDTH-1:0]            dimensionality,
  input  logic [NUM_DIMS-1:0][CNT_WIDTH-1:0]  extent,
  input  logic [TIME_WIDTH-1:0]               sched_start,
  input  logic [NUM_DIMS-1:0][TIME_WIDTH-1:0] sched_delta,
  input  logic [ADDR_WIDTH-1:0]               addr_start,
  input  logic [NUM_DIMS-1:0][ADDR_WIDTH-1:0] addr_delta,
  lake_sched_ctrl_if.master                   port
);

  sched_state_t             state_q, state_d;
  logic [TIME_WIDTH-1:0]    cycle_cnt;
  logic [TIME_WIDTH-1:0]    sched_time;
  logic [ADDR_WIDTH-1:0]    addr_r;
  logic [DIM_SEL_WIDTH-1:0] enc_sel;
  logic                     last;
  logic                     in_run;
  logic                     match;
  logic                     fire;
  logic                     stall;
  logic [TIME_WIDTH-1:0]    time_inc;
  logic [ADDR_WIDTH-1:0]    addr_inc;

  assign in_run = (state_q == ST_RUN);
  assign match  = in_run && (cycle_cnt == sched_time);

`ifdef LAKE_SCHED_CTRL_BACKPRESSURE_EN
  // A match without port_ready freezes the counter so the same time matches again.
  assign fire  = match && port.port_ready && !flush;
  assign stall = match && !port.port_ready;
  assign port.overrun = 1'b0;
`else
  logic overrun_q;

  assign fire  = match && !flush;
  assign stall = 1'b0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      overrun_q <= 1'b0;
    end else if (fire && !port.port_ready) begin
      overrun_q <= 1'b1;
    end
  end

  assign port.overrun = overrun_q;
`endif

  lake_iter_dom #(
    .NUM_DIMS (NUM_DIMS),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_iter_dom (
    .clk           (clk),
    .rst           (rst),
    .clear         (flush || !in_run),
    .advance       (fire),
    .dimensionality(dimensionality),
    .extent        (extent),
    .mux_sel       (enc_sel),
    .last          (last)
  );

  always_comb begin
    time_inc = '0;
    addr_inc = '0;
    for (int d = 0; d < NUM_DIMS; d++) begin
      if (int'(enc_sel) == d) begin
        time_inc = sched_delta[d];
        addr_inc = addr_delta[d];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable && !flush) state_d = ST_RUN;
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (fire && last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (flush) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outside RUN the datapath is held at its start point so the first RUN cycle
  // begins with cycle_cnt=0, sched_time=sched_start and addr_r=addr_start.
  always_ff @(posedge clk) begin
    if (rst || flush || !in_run) begin
      cycle_cnt  <= '0;
      sched_time <= sched_start;
      addr_r     <= addr_start;
    end else begin
      if (!stall) begin
        cycle_cnt <= cycle_cnt + TIME_WIDTH'(1);
      end
      if (fire && !last) begin
        sched_time <= sched_time + time_inc;
        addr_r     <= addr_r + addr_inc;
      end
    end
  end

  assign port.step    = fire;
  assign port.addr    = in_run ? addr_r : addr_start;
  assign port.mux_sel = in_run ? enc_sel : '0;
  assign port.done    = (state_q == ST_DONE);

endmodule
